// File: rtl/dwconv_sched_if.sv
// ---------------------------------------------------------------------------
// dwconv_sched_if
//
// Bundle of every signal between the frame scheduler, the network
// sequencer, the two feature-map buffers and the convolution pipeline.
//
//   sequencer : start, gap_cycles (to scheduler); busy, done, err (from it)
//   input buf : rd_en, rd_addr (from scheduler); rd_data (to it)
//   pipeline  : conv_in_vld, conv_in_din (from scheduler);
//               conv_dout, conv_dout_vld, conv_dout_end (to it)
//   output buf: wr_en, wr_addr, wr_data (from scheduler)
//
// Modports:
//   slave  - the scheduler itself
//   master - the environment around it (sequencer, buffers, pipeline)
// ---------------------------------------------------------------------------
interface dwconv_sched_if #(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 3,
    parameter int ADDR_W         = 10
);
    logic                            start;
    logic [3:0]                      gap_cycles;
    logic                            busy;
    logic                            done;
    logic                            err;
    logic                            rd_en;
    logic [ADDR_W-1:0]               rd_addr;
    logic [INPUT_CHANNEL*N-1:0]      rd_data;
    logic                            conv_in_vld;
    logic [INPUT_CHANNEL*N-1:0]      conv_in_din;
    logic [OUTPUT_CHANNEL*N-1:0]     conv_dout;
    logic                            conv_dout_vld;
    logic                            conv_dout_end;
    logic                            wr_en;
    logic [ADDR_W-1:0]               wr_addr;
    logic [OUTPUT_CHANNEL*N-1:0]     wr_data;

    modport slave (
        input  start, gap_cycles, rd_data, conv_dout, conv_dout_vld, conv_dout_end,
        output busy, done, err, rd_en, rd_addr, conv_in_vld, conv_in_din,
               wr_en, wr_addr, wr_data
    );

    modport master (
        output start, gap_cycles, rd_data, conv_dout, conv_dout_vld, conv_dout_end,
        input  busy, done, err, rd_en, rd_addr, conv_in_vld, conv_in_din,
               wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/dwconv_sched.sv
// ---------------------------------------------------------------------------
// dwconv_sched
//
// Frame scheduler for one depthwise-separable convolution layer. On start it
// reads the whole INPUT_SIZE x INPUT_SIZE map out of the input buffer and
// streams it into the pipeline, writes every pipeline output pixel into the
// output buffer at sequential addresses, and reports done or err.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset
//   bus         - dwconv_sched_if.slave (sequencer, buffers, pipeline)
//   dbg_state_o - current FSM state (IDLE=0, FEED=1, DRAIN=2)
//
// Optional feature macro: DWSCHED_THROTTLE_EN
//   defined   - after each read, rd_en stays low for gap_cycles cycles
//               (gap_cycles captured at start)
//   undefined - reads are back-to-back, gap_cycles unused
//
// Handshake: all streams are valid-qualified with no backpressure. A beat
// exists in exactly the cycle its valid (rd_en, conv_in_vld, conv_dout_vld,
// wr_en) is high and is consumed by the receiver in that same cycle; there
// is no ready, so the receiver must always accept.
// ---------------------------------------------------------------------------
module dwconv_sched #(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 3,
    parameter int INPUT_SIZE     = 6,
    parameter int OUTPUT_SIZE    = 4,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT        = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dwconv_sched_if.slave        bus,
    output logic [1:0]           dbg_state_o
);

    localparam int IN_PIX  = INPUT_SIZE * INPUT_SIZE;
    localparam int OUT_PIX = OUTPUT_SIZE * OUTPUT_SIZE;
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(IN_PIX - 1);
    // Write pointer has one extra bit so it can hold OUT_PIX itself.
    localparam logic [ADDR_W:0]   OUT_CNT = (ADDR_W + 1)'(OUT_PIX);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [ADDR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]             wr_ptr_q, wr_ptr_d;
    logic [IDLE_W-1:0]           idle_cnt_q, idle_cnt_d;
    logic                        err_q, err_d;
    logic                        early_end_q, early_end_d;
    logic                        done_q, done_d;
    logic                        in_vld_q;
    logic                        wr_en_q;
    logic [ADDR_W-1:0]           wr_addr_q;
    logic [OUTPUT_CHANNEL*N-1:0] wr_data_q;

`ifdef DWSCHED_THROTTLE_EN
    logic [3:0]                  gap_cnt_q, gap_cnt_d;
    logic [3:0]                  gap_cfg_q, gap_cfg_d;
`else
    logic                        unused_gap;
    assign unused_gap = ^bus.gap_cycles;
`endif

    logic                        busy;
    logic                        rd_en;
    logic                        wr_accept;
    logic                        wr_over;
    logic [ADDR_W:0]             wr_cnt_after;

    assign busy = (state_q != S_IDLE);

`ifdef DWSCHED_THROTTLE_EN
    assign rd_en = (state_q == S_FEED) && (gap_cnt_q == 4'd0);
`else
    assign rd_en = (state_q == S_FEED);
`endif

    // Output pixels are taken only while a frame is active and room remains.
    assign wr_accept    = busy && bus.conv_dout_vld && (wr_ptr_q != OUT_CNT);
    assign wr_over      = busy && bus.conv_dout_vld && (wr_ptr_q == OUT_CNT);
    // Count including a pixel that arrives together with conv_dout_end.
    assign wr_cnt_after = wr_ptr_q + {{ADDR_W{1'b0}}, wr_accept};

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_cnt_after;
        idle_cnt_d  = idle_cnt_q;
        err_d       = err_q | wr_over;
        early_end_d = early_end_q;
        done_d      = 1'b0;
`ifdef DWSCHED_THROTTLE_EN
        gap_cnt_d   = gap_cnt_q;
        gap_cfg_d   = gap_cfg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_FEED;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    idle_cnt_d  = '0;
                    err_d       = 1'b0;
                    early_end_d = 1'b0;
`ifdef DWSCHED_THROTTLE_EN
                    gap_cnt_d   = 4'd0;
                    gap_cfg_d   = bus.gap_cycles;
`endif
                end
            end
            S_FEED: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
`ifdef DWSCHED_THROTTLE_EN
                    gap_cnt_d = gap_cfg_q;
`endif
                    if (rd_ptr_q == LAST_RD) begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef DWSCHED_THROTTLE_EN
                else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
`endif
                // A premature end marks the frame bad; FEED still completes.
                if (bus.conv_dout_end) begin
                    err_d       = 1'b1;
                    early_end_d = 1'b1;
                end
            end
            S_DRAIN: begin
                idle_cnt_d = bus.conv_dout_vld ? '0 : idle_cnt_q + IDLE_W'(1);
                if (early_end_q) begin
                    state_d = S_IDLE;
                end else if (bus.conv_dout_end) begin
                    state_d = S_IDLE;
                    if (wr_cnt_after != OUT_CNT) begin
                        err_d = 1'b1;
                    end else if (!err_q && !wr_over) begin
                        done_d = 1'b1;
                    end
                end else if (!bus.conv_dout_vld && (idle_cnt_q == IDLE_LAST)) begin
                    // This cycle is the TIMEOUT-th idle one.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            idle_cnt_q  <= '0;
            err_q       <= 1'b0;
            early_end_q <= 1'b0;
            done_q      <= 1'b0;
            in_vld_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef DWSCHED_THROTTLE_EN
            gap_cnt_q   <= 4'd0;
            gap_cfg_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            idle_cnt_q  <= idle_cnt_d;
            err_q       <= err_d;
            early_end_q <= early_end_d;
            done_q      <= done_d;
            in_vld_q    <= rd_en;
            wr_en_q     <= wr_accept;
            if (wr_accept) begin
                wr_addr_q <= wr_ptr_q[ADDR_W-1:0];
                wr_data_q <= bus.conv_dout;
            end
`ifdef DWSCHED_THROTTLE_EN
            gap_cnt_q   <= gap_cnt_d;
            gap_cfg_q   <= gap_cfg_d;
`endif
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.rd_en       = rd_en;
    assign bus.rd_addr     = rd_ptr_q;
    assign bus.conv_in_vld = in_vld_q;
    // Buffer data passes straight through; held at zero outside valid beats
    // so that reset leaves every output at zero.
    assign bus.conv_in_din = in_vld_q ? bus.rd_data : '0;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_dwconv_sched.sv
// ---------------------------------------------------------------------------
// tb_dwconv_sched
//
// Directed bench for dwconv_sched (INPUT_SIZE=6, OUTPUT_SIZE=4, TIMEOUT=20).
// The input buffer is a behavioural RAM whose word at address a is
// in_word(a); the pipeline is played by the main sequence, which drives
// output pixels out_word(i) and end markers directly.
// ---------------------------------------------------------------------------
module tb_dwconv_sched;

    localparam int N       = 16;
    localparam int IC      = 3;
    localparam int OC      = 3;
    localparam int IS      = 6;
    localparam int OS      = 4;
    localparam int AW      = 10;
    localparam int TO      = 20;
    localparam int IN_PIX  = IS * IS;
    localparam int OUT_PIX = OS * OS;
    localparam int OW      = OC * N;

`ifdef DWSCHED_THROTTLE_EN
    localparam int EXP_GAP = 2;
`else
    localparam int EXP_GAP = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic [1:0]    dbg_state;
    int            vec_cnt;
    int            err_cnt;
    logic [OW-1:0] exp_q[$];
    int            waited;

    dwconv_sched_if #(.N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC), .ADDR_W(AW)) bus ();

    dwconv_sched #(
        .N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC), .INPUT_SIZE(IS),
        .OUTPUT_SIZE(OS), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- models ----------------
    function automatic logic [IC*N-1:0] in_word(input logic [AW-1:0] a);
        logic [15:0] x;
        x = {6'd0, a};
        return {x + 16'h1000, x + 16'h2000, x + 16'h3000};
    endfunction

    function automatic logic [OW-1:0] out_word(input int i);
        logic [15:0] x;
        x = 16'(i);
        return {x ^ 16'hA5A5, x + 16'h0100, 16'hC000 | x};
    endfunction

    // Input buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= in_word(bus.rd_addr);
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_err_clr", bus.err, 0);
    endtask

    // Walk the FEED phase cycle by cycle. early_at: cycle for a premature
    // conv_dout_end pulse; busy_start_at: cycle for a start pulse while busy;
    // rst_at: read index at which reset is asserted (feed then stops).
    task automatic feed(input int early_at, input int busy_start_at, input int rst_at);
        int   t_max;
        logic prev_en;
        int   prev_addr;
        logic exp_en;
        t_max     = (IN_PIX - 1) * (EXP_GAP + 1);
        prev_en   = 1'b0;
        prev_addr = 0;
        for (int t = 0; t <= t_max; t++) begin
            exp_en = ((t % (EXP_GAP + 1)) == 0);
            chk("rd_en", bus.rd_en, exp_en);
            if (exp_en) chk("rd_addr", bus.rd_addr, t / (EXP_GAP + 1));
            chk("in_vld", bus.conv_in_vld, prev_en);
            if (prev_en) chk("in_din", bus.conv_in_din, in_word(AW'(prev_addr)));
            if (exp_en && (t / (EXP_GAP + 1)) == rst_at) begin
                rst_n = 1'b0;
                return;
            end
            prev_en   = exp_en;
            prev_addr = t / (EXP_GAP + 1);
            bus.start         = (t == busy_start_at);
            bus.conv_dout_end = (t == early_at);
            @(negedge clk);
        end
        bus.start         = 1'b0;
        bus.conv_dout_end = 1'b0;
        chk("feed_end_rd_en", bus.rd_en, 0);
        chk("feed_end_in_vld", bus.conv_in_vld, 1);
        chk("feed_end_in_din", bus.conv_in_din, in_word(AW'(IN_PIX - 1)));
        chk("feed_end_busy", bus.busy, 1);
    endtask

    // Play n pipeline outputs, one per cycle; end marks the last one.
    task automatic drive_outputs(input int n, input bit with_end);
        for (int i = 0; i < n; i++) begin
            bus.conv_dout_vld = 1'b1;
            bus.conv_dout     = out_word(i);
            bus.conv_dout_end = with_end && (i == n - 1);
            if (i < OUT_PIX) exp_q.push_back(out_word(i));
            @(negedge clk);
            if (i < OUT_PIX) begin
                chk("wr_en", bus.wr_en, 1);
                chk("wr_addr", bus.wr_addr, i);
                chk("wr_data", bus.wr_data, exp_q.pop_front());
            end else begin
                chk("wr_en_overflow", bus.wr_en, 0);
            end
            if (i < n - 1) chk("done_early", bus.done, 0);
        end
        bus.conv_dout_vld = 1'b0;
        bus.conv_dout_end = 1'b0;
        bus.conv_dout     = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_rd_en"}, bus.rd_en, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 0);
        chk({tag, "_in_vld"}, bus.conv_in_vld, 0);
        chk({tag, "_in_din"}, bus.conv_in_din, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vec_cnt           = 0;
        err_cnt           = 0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.gap_cycles    = 4'd2;
        bus.conv_dout     = '0;
        bus.conv_dout_vld = 1'b0;
        bus.conv_dout_end = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame; a start pulse during FEED must be ignored.
        do_start();
        feed(-1, 3, -1);
        drive_outputs(OUT_PIX, 1'b1);
        chk("nom_done", bus.done, 1);
        chk("nom_err", bus.err, 0);
        chk("nom_busy", bus.busy, 0);
        @(negedge clk);
        chk("nom_done_pulse", bus.done, 0);
        chk("nom_wr_en_off", bus.wr_en, 0);
        // Pipeline output in IDLE is ignored.
        bus.conv_dout_vld = 1'b1;
        bus.conv_dout     = out_word(99);
        @(negedge clk);
        bus.conv_dout_vld = 1'b0;
        chk("idle_vld_wr_en", bus.wr_en, 0);
        chk("idle_vld_err", bus.err, 0);

        // Short frame: 15 outputs then end.
        do_start();
        feed(-1, -1, -1);
        drive_outputs(OUT_PIX - 1, 1'b1);
        chk("short_err", bus.err, 1);
        chk("short_done", bus.done, 0);
        chk("short_state", dbg_state, 0);

        // Premature end during FEED.
        do_start();
        feed(5, -1, -1);
        chk("early_err", bus.err, 1);
        chk("early_state_drain", dbg_state, 2);
        @(negedge clk);
        chk("early_busy", bus.busy, 0);
        chk("early_done", bus.done, 0);

        // Overflow: 17 outputs, end on the 17th.
        do_start();
        feed(-1, -1, -1);
        drive_outputs(OUT_PIX + 1, 1'b1);
        chk("ovf_err", bus.err, 1);
        chk("ovf_done", bus.done, 0);
        chk("ovf_busy", bus.busy, 0);

        // Stall: outputs stop without an end marker.
        do_start();
        feed(-1, -1, -1);
        drive_outputs(10, 1'b0);
        chk("stall_err_before", bus.err, 0);
        waited = 0;
        while (!bus.err && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("stall_timeout_cycles", waited, TO);
        chk("stall_busy", bus.busy, 0);
        chk("stall_done", bus.done, 0);

        // Reset at read 10, then a clean restart.
        do_start();
        feed(-1, -1, 10);
        @(negedge clk);
        check_zero_outputs("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        feed(-1, -1, -1);
        drive_outputs(OUT_PIX, 1'b1);
        chk("restart_done", bus.done, 1);
        chk("restart_err", bus.err, 0);
        chk("restart_busy", bus.busy, 0);
        chk("sb_empty", exp_q.size(), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
